// File: rtl/pdm_pkg.sv
// pdm_pkg
//   Shared helpers for the PDM decimator.
//   width_ok()     : legality check of the output width against the window size.
//   sat_to_width() : clamps a wide signed value to the signed range of a w-bit word.
package pdm_pkg;

    // The output must be at least as wide as the window count. Otherwise the
    // window-to-PCM scaling would be a right shift, which this datapath does not provide.
    function automatic bit width_ok(input int out_w, input int win_log2);
        return out_w >= win_log2;
    endfunction

    function automatic logic signed [63:0] sat_to_width(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        return v;
    endfunction

endpackage

// File: rtl/pdm_chan.sv
// pdm_chan
//   One channel of the PDM decimator. It counts the ones in the current window,
//   centres the count at window end, and boxcar-averages the result against the
//   previous windows. It then scales and saturates to signed PCM and tracks the
//   running peaks.
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   en          sample enable; low holds accumulator and history
//   clr         synchronous clear of the peak registers
//   win_end     last sample of the window is present this cycle (includes en)
//   pcm_vld     shared strobe: pcm holds a new value this cycle
//   pdm_bit     this channel's PDM bit
//   pcm         signed PCM result, updated on the edge that ends the window
//   pk_max      largest pcm seen since reset/clr
//   pk_min      smallest pcm seen since reset/clr
module pdm_chan
    import pdm_pkg::*;
#(
    parameter int WIN_LOG2 = 11,
    parameter int AVG_LOG2 = 1,
    parameter int OUT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic                    win_end,
    input  logic                    pcm_vld,
    input  logic                    pdm_bit,
    output logic signed [OUT_W-1:0] pcm,
    output logic signed [OUT_W-1:0] pk_max,
    output logic signed [OUT_W-1:0] pk_min
);

    localparam int CW        = WIN_LOG2 + 1;
    localparam int SW        = CW + AVG_LOG2;
    localparam int AVG_DEPTH = 1 << AVG_LOG2;
    localparam int SHIFT     = OUT_W - WIN_LOG2;
    // The newest centred count is summed straight from the combinational path.
    // Only the older AVG_DEPTH-1 entries need storage.
    localparam int HD        = (AVG_DEPTH > 1) ? AVG_DEPTH - 1 : 1;
    localparam logic [CW-1:0] MID = CW'(1 << (WIN_LOG2 - 1));

    logic        [CW-1:0]    acc;
    logic        [CW-1:0]    acc_nxt;
    logic signed [CW-1:0]    cen;
    logic signed [CW-1:0]    hist [HD];
    logic signed [SW-1:0]    sum;
    logic signed [63:0]      scaled;
    logic signed [OUT_W-1:0] pcm_nxt;

    // The window-end sample is folded in before centring, so it counts toward this window.
    always_comb begin
        acc_nxt = acc + CW'(pdm_bit);
        cen     = signed'(acc_nxt - MID);
        sum     = SW'(cen);
        for (int i = 0; i < AVG_DEPTH - 1; i++)
            sum = sum + SW'(hist[i]);
        scaled  = (64'(sum) >>> AVG_LOG2) <<< SHIFT;
        pcm_nxt = OUT_W'(sat_to_width(scaled, OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pcm <= '0;
            for (int i = 0; i < HD; i++)
                hist[i] <= '0;
        end else begin
            if (en)
                acc <= win_end ? '0 : acc_nxt;
            if (win_end) begin
                pcm     <= pcm_nxt;
                hist[0] <= cen;
                for (int i = 1; i < HD; i++)
                    hist[i] <= hist[i-1];
            end
        end
    end

    // Peaks follow pcm one cycle behind the strobe.
    // A clear that lands on a strobe restarts tracking from the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pk_max <= '0;
            pk_min <= '0;
        end else if (clr && pcm_vld) begin
            pk_max <= pcm;
            pk_min <= pcm;
        end else if (clr) begin
            pk_max <= '0;
            pk_min <= '0;
        end else if (pcm_vld) begin
            if (pcm > pk_max)
                pk_max <= pcm;
            if (pcm < pk_min)
                pk_min <= pcm;
        end
    end

endmodule

// File: rtl/pdm_decimator.sv
// pdm_decimator
//   Multi-channel PDM-to-PCM demodulator with per-channel peak tracking.
//   This module holds the shared window counter, output strobe and warm-up
//   flag, and instantiates one pdm_chan per channel.
// Ports
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   en       sample enable; low freezes window progress
//   clr      synchronous clear of all peak trackers
//   pdm_in   one PDM bit per channel
//   pcm_out  signed PCM per channel, ch0 in [OUT_W-1:0]
//   pcm_vld  one-cycle strobe marking new pcm_out values
//   primed   sticky; high once the averaging history is fully populated
//   pk_max   per-channel maximum of pcm_out since reset/clr
//   pk_min   per-channel minimum of pcm_out since reset/clr
module pdm_decimator
    import pdm_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int WIN_LOG2 = 11,
    parameter int AVG_LOG2 = 1,
    parameter int OUT_W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    input  logic [NUM_CH-1:0]       pdm_in,
    output logic [NUM_CH*OUT_W-1:0] pcm_out,
    output logic                    pcm_vld,
    output logic                    primed,
    output logic [NUM_CH*OUT_W-1:0] pk_max,
    output logic [NUM_CH*OUT_W-1:0] pk_min
);

    generate
        if (!width_ok(OUT_W, WIN_LOG2)) begin : g_bad_width
            $error("pdm_decimator: OUT_W (%0d) must be >= WIN_LOG2 (%0d)", OUT_W, WIN_LOG2);
        end
    endgenerate

    localparam logic [AVG_LOG2:0] PRIME_AT = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

    logic [WIN_LOG2-1:0] win_cnt;
    logic [AVG_LOG2:0]   vld_cnt;
    logic                win_end;

    assign win_end = en && (win_cnt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt <= '0;
            vld_cnt <= '0;
            pcm_vld <= 1'b0;
            primed  <= 1'b0;
        end else begin
            pcm_vld <= win_end;
            if (en)
                win_cnt <= win_cnt + WIN_LOG2'(1);
            // Once primed, the count no longer matters, so it stops advancing.
            if (win_end && !primed) begin
                vld_cnt <= vld_cnt + (AVG_LOG2 + 1)'(1);
                if (vld_cnt == PRIME_AT)
                    primed <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pdm_chan #(
            .WIN_LOG2 (WIN_LOG2),
            .AVG_LOG2 (AVG_LOG2),
            .OUT_W    (OUT_W)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .clr     (clr),
            .win_end (win_end),
            .pcm_vld (pcm_vld),
            .pdm_bit (pdm_in[g]),
            .pcm     (pcm_out[g*OUT_W +: OUT_W]),
            .pk_max  (pk_max[g*OUT_W +: OUT_W]),
            .pk_min  (pk_min[g*OUT_W +: OUT_W])
        );
    end

endmodule
